// File: rtl/gol_pkg.sv
// Shared Game of Life definitions: framebuffer geometry,
// LFSR taps, seeder FSM states and small helpers.
package gol_pkg;

   localparam int FB_WIDTH  = 480;
   localparam int FB_HEIGHT = 272;
   localparam int FB_ADDR_W = 17;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEED = 2'd1,
      ST_DONE = 2'd2
   } seed_state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // An all-zero Galois LFSR never leaves zero.
   function automatic logic [15:0] fix_seed(input logic [15:0] s);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

endpackage

// File: rtl/fb_seeder_lfsr16.sv
// 16-bit right-shifting Galois LFSR with reset value,
// runtime load and step enable.
module lfsr16
   import gol_pkg::*;
#(
   parameter logic [15:0] RST_VAL = 16'h0001
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [15:0] i_seed,
   input  logic        i_step,
   output logic [15:0] o_q
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_q <= fix_seed(RST_VAL);
      end else if (i_load) begin
         o_q <= fix_seed(i_seed);
      end else if (i_step) begin
         o_q <= lfsr_next(o_q);
      end
   end

endmodule

// File: rtl/fb_seeder.sv
// Framebuffer initial-pattern generator: sweeps every cell once
// writing LFSR-derived alive/dead bits, then pulses done.
module fb_seeder
   import gol_pkg::*;
#(
   parameter int          WIDTH      = FB_WIDTH,
   parameter int          HEIGHT     = FB_HEIGHT,
   parameter int          ADDR_W     = FB_ADDR_W,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter int          THRESH     = 4,
   parameter int          AUTO_START = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_data,
   output logic              o_we,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] LAST =
      ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [4:0] TH = 5'(THRESH);
   localparam logic [15:0] SEED_EFF = fix_seed(SEED);
   localparam seed_state_t RST_ST =
      (AUTO_START != 0) ? ST_SEED : ST_IDLE;

   seed_state_t       state_q;
   seed_state_t       nxt_state;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] nxt_cnt;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr;
   logic [15:0]       lfsr_q;

   logic              nxt_data;
   logic              nxt_done;

   lfsr16 #(
      .RST_VAL (SEED_EFF)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (1'b0),
      .i_seed  (SEED_EFF),
      .i_step  (wr),
      .o_q     (lfsr_q)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
      end else begin
         state_q <= nxt_state;
         cnt_q   <= nxt_cnt;
      end
   end

   // An accepted start issues address 0 on the very next
   // edge, so the counter is taken as zero from IDLE.
   always_comb begin
      nxt_state = state_q;
      nxt_cnt   = cnt_q;
      wr        = 1'b0;
      wr_addr   = '0;
      unique case (state_q)
         ST_IDLE: wr = i_start;
         ST_SEED: begin
            wr      = 1'b1;
            wr_addr = cnt_q;
         end
         ST_DONE: nxt_state = ST_IDLE;
         default: nxt_state = ST_IDLE;
      endcase
      if (wr) begin
         if (wr_addr == LAST) begin
            nxt_state = ST_DONE;
            nxt_cnt   = '0;
         end else begin
            nxt_state = ST_SEED;
            nxt_cnt   = wr_addr + 1'b1;
         end
      end
   end

   always_comb begin
      nxt_data = wr && ({1'b0, lfsr_q[3:0]} < TH);
      nxt_done = (state_q == ST_DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_addr <= '0;
         o_data <= 1'b0;
         o_we   <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_addr <= wr_addr;
         o_data <= nxt_data;
         o_we   <= wr;
         o_busy <= wr;
         o_done <= nxt_done;
      end
   end

endmodule

// File: tb/tb_fb_seeder.sv
// Scoreboard bench for fb_seeder on an 8x4 grid: auto-start,
// manual start, held start, mid-sweep reset and zero seed.
module tb_fb_seeder;

   typedef struct packed {
      logic [16:0] addr;
      logic        data;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start_a, start_b;
   logic start_z = 1'b0;

   logic [16:0] addr_a, addr_b, addr_z;
   logic data_a, we_a, busy_a, done_a;
   logic data_b, we_b, busy_b, done_b;
   logic data_z, we_z, busy_z, done_z;

   int checks = 0;
   int errors = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qz[$];
   logic [15:0] la, lb, lz;

   logic first_a [0:2];
   int widx_a = 0;
   int widx_b = 0;
   int wr_cnt_b = 0;
   int sweep_b = 0;
   logic [31:0] sw_b [0:7];
   int alive_z = 0;

   always #5 clk = ~clk;

   fb_seeder #(
      .WIDTH(8), .HEIGHT(4), .ADDR_W(17),
      .SEED(16'hACE1), .THRESH(4), .AUTO_START(1)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
      .o_addr(addr_a), .o_data(data_a), .o_we(we_a),
      .o_busy(busy_a), .o_done(done_a)
   );

   fb_seeder #(
      .WIDTH(8), .HEIGHT(4), .ADDR_W(17),
      .SEED(16'hACE1), .THRESH(4), .AUTO_START(0)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
      .o_addr(addr_b), .o_data(data_b), .o_we(we_b),
      .o_busy(busy_b), .o_done(done_b)
   );

   fb_seeder #(
      .WIDTH(8), .HEIGHT(4), .ADDR_W(17),
      .SEED(16'h0000), .THRESH(4), .AUTO_START(1)
   ) dut_z (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_z),
      .o_addr(addr_z), .o_data(data_z), .o_we(we_z),
      .o_busy(busy_z), .o_done(done_z)
   );

   task automatic chk(input string n,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic push_sweep(input int d);
      logic [15:0] cur;
      exp_t e;
      cur = (d == 0) ? la : (d == 1) ? lb : lz;
      for (int i = 0; i < 32; i++) begin
         e.addr = 17'(i);
         e.data = (cur[3:0] < 4'd4);
         e.done = 1'b0;
         if (d == 0) qa.push_back(e);
         else if (d == 1) qb.push_back(e);
         else qz.push_back(e);
         cur = step(cur);
      end
      e = '{addr: 17'd0, data: 1'b0, done: 1'b1};
      if (d == 0) begin qa.push_back(e); la = cur; end
      else if (d == 1) begin qb.push_back(e); lb = cur; end
      else begin qz.push_back(e); lz = cur; end
   endtask

   task automatic cmp(input string n, input exp_t e,
                      input logic [16:0] a, input logic d,
                      input logic w, input logic dn);
      chk({n, "_we"}, w, !e.done);
      chk({n, "_done"}, dn, e.done);
      if (!e.done) begin
         chk({n, "_addr"}, a, e.addr);
         chk({n, "_data"}, d, e.data);
      end
   endtask

   task automatic unexp(input string n);
      checks++;
      errors++;
      $display("FAIL %s_unexpected output with empty queue", n);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         widx_a = 0;
      end else begin
         chk("a_busy_eq_we", busy_a, we_a);
         chk("b_busy_eq_we", busy_b, we_b);
         chk("z_busy_eq_we", busy_z, we_z);
         if (we_a || done_a) begin
            if (qa.size() == 0) unexp("a");
            else cmp("a", qa.pop_front(), addr_a, data_a, we_a, done_a);
            if (we_a) begin
               if (widx_a < 3) first_a[widx_a] = data_a;
               widx_a++;
            end
         end
         if (we_b || done_b) begin
            if (qb.size() == 0) unexp("b");
            else cmp("b", qb.pop_front(), addr_b, data_b, we_b, done_b);
            if (we_b) begin
               wr_cnt_b++;
               if (sweep_b < 8 && widx_b < 32)
                  sw_b[sweep_b][widx_b] = data_b;
               widx_b++;
            end
            if (done_b) begin
               sweep_b++;
               widx_b = 0;
            end
         end
         if (we_z || done_z) begin
            if (qz.size() == 0) unexp("z");
            else cmp("z", qz.pop_front(), addr_z, data_z, we_z, done_z);
            if (we_z && data_z) alive_z++;
         end
      end
   end

   task automatic wait_done_b(input string n);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done_b) break;
      end
      if (k == 60) begin
         checks++;
         errors++;
         $display("FAIL %s timeout waiting for done_b", n);
      end
   endtask

   task automatic drain_b(input string n);
      int k;
      for (k = 0; k < 120; k++) begin
         @(negedge clk);
         #2;
         if (qb.size() == 0) break;
      end
      chk(n, qb.size(), 0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      la = 16'hACE1;
      lb = 16'hACE1;
      lz = 16'h0001;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_we_a", we_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_addr_a", addr_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_data_a", data_a, 0);
      chk("rst_we_b", we_b, 0);
      chk("rst_we_z", we_z, 0);

      // auto-start sweep on dut_a and zero-seed dut_z
      push_sweep(0);
      push_sweep(2);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (33) @(negedge clk);
      #2;
      chk("s1_drain_a", qa.size(), 0);
      chk("s6_drain_z", qz.size(), 0);
      chk("s1_data0", first_a[0], 1);
      chk("s1_data1", first_a[1], 1);
      chk("s1_data2", first_a[2], 0);
      repeat (3) @(negedge clk);
      #1;
      chk("s1_busy_after", busy_a, 0);
      chk("s2_no_auto_b", wr_cnt_b, 0);

      // manual start, latency 1
      push_sweep(1);
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      #1;
      chk("s2_lat_we", we_b, 1);
      chk("s2_lat_addr", addr_b, 0);
      wait_done_b("s2");

      // earliest restart: start in the cycle after done
      push_sweep(1);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      #1;
      chk("s3_restart_we", we_b, 1);
      chk("s3_restart_addr", addr_b, 0);
      wait_done_b("s3");
      #2;
      chk("s3_differs", (sw_b[0] != sw_b[1]), 1);

      // start held high across a whole sweep
      @(negedge clk);
      push_sweep(1);
      push_sweep(1);
      start_b = 1'b1;
      repeat (40) @(negedge clk);
      start_b = 1'b0;
      drain_b("s4_drain_b");
      repeat (4) @(negedge clk);
      chk("s4_sweeps", sweep_b, 4);
      chk("s4_writes", wr_cnt_b, 128);

      // reset in the middle of a sweep on dut_a
      push_sweep(0);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (k = 0; k < 40; k++) begin
         if (we_a && addr_a == 17'd17) break;
         @(negedge clk);
      end
      chk("s5_reached_17", (k < 40), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s5_async_we", we_a, 0);
      chk("s5_async_busy", busy_a, 0);
      chk("s5_async_addr", addr_a, 0);
      qa.delete();
      la = 16'hACE1;
      lb = 16'hACE1;
      lz = 16'h0001;
      alive_z = 0;
      push_sweep(0);
      push_sweep(2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (33) @(negedge clk);
      #2;
      chk("s5_drain_a", qa.size(), 0);
      chk("s5_drain_z", qz.size(), 0);
      chk("s5_data0", first_a[0], 1);
      chk("s5_data1", first_a[1], 1);
      chk("s5_data2", first_a[2], 0);
      chk("s6_alive", (alive_z > 0), 1);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
